window_motor_sequencer: RTL and testbench

Sequences the single window motor driver (cw = open, ccw = close) from a pre-debounced one-cycle button pulse. Adds end-of-travel limit switches, a run-time watchdog, anti-pinch auto-reverse on close, and a mandatory dead-time between any motor stop and the next start. Sits between the button conditioning logic and the H-bridge pins.

---
 rtl/window_pkg.sv | 23 ++
 rtl/window_timer.sv | 21 ++
 rtl/window_motor_sequencer.sv | 107 ++++++++++
 tb/tb_window_motor_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/window_pkg.sv
// window_pkg: shared state/event encodings and default timing for the window motor sequencer.
package window_pkg;
  localparam int RUN_CYCLES_DEF = 1000;
  localparam int DEAD_CYCLES_DEF = 16;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    IDLE_CLOSED = 3'd0,
    OPENING     = 3'd1,
    IDLE_OPEN   = 3'd2,
    CLOSING     = 3'd3,
    BRAKE       = 3'd4,
    FAULT       = 3'd5
  } state_t;
  // Listed from highest to lowest priority; only the winner is acted on each cycle.
  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_BOTH    = 3'd1,
    EV_LIMIT   = 3'd2,
    EV_OBST    = 3'd3,
    EV_TIMEOUT = 3'd4,
    EV_PRESS   = 3'd5
  } event_t;
endpackage

// File: rtl/window_timer.sv
// window_timer: loadable down-counter that sticks at zero.
// Ports: clk, n_reset (sync, active-low), load/load_val (load wins over en),
//        en (decrement while nonzero), zero (count == 0).
module window_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clk) begin
    if (!n_reset) count <= '0;
    else if (load) count <= load_val;
    else if (en && count != '0) count <= count - 1'b1;
  end
  assign zero = count == '0;
endmodule

// File: rtl/window_motor_sequencer.sv
// window_motor_sequencer: drives the window H-bridge from a button pulse with limits, watchdog, anti-pinch and dead-time.
// Ports: clk, n_reset (sync, active-low); button_press (1-cycle pulse), limit_open, limit_closed,
//        obstruction (level); motor_cw (open), motor_ccw (close), busy, fault, pinch_seen (sticky).
module window_motor_sequencer
  import window_pkg::*;
#(
  parameter int RUN_CYCLES  = RUN_CYCLES_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic clk,
  input  logic n_reset,
  input  logic button_press,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic obstruction,
  output logic motor_cw,
  output logic motor_ccw,
  output logic busy,
  output logic fault,
  output logic pinch_seen
);
  state_t state, state_nxt, target, target_nxt;
  event_t ev;
  logic pinch_nxt, run_state, run_zero, run_load, dead_zero, dead_load;
  assign run_state = state == OPENING || state == CLOSING;
  // Timers reload only on the edge that enters their state, so a run always starts from a full budget.
  assign run_load = (state_nxt == OPENING || state_nxt == CLOSING) && state_nxt != state;
  assign dead_load = state_nxt == BRAKE && state != BRAKE;
  window_timer #(.CNT_W(CNT_W)) u_run (
    .clk(clk), .n_reset(n_reset), .load(run_load), .en(run_state),
    .load_val(CNT_W'(RUN_CYCLES - 1)), .zero(run_zero)
  );
  window_timer #(.CNT_W(CNT_W)) u_dead (
    .clk(clk), .n_reset(n_reset), .load(dead_load), .en(state == BRAKE),
    .load_val(CNT_W'(DEAD_CYCLES - 1)), .zero(dead_zero)
  );
  always_comb begin
    ev = (limit_open && limit_closed) ? EV_BOTH :
         ((state == OPENING && limit_open) || (state == CLOSING && limit_closed)) ? EV_LIMIT :
         (state == CLOSING && obstruction) ? EV_OBST :
         (run_state && run_zero) ? EV_TIMEOUT :
         button_press ? EV_PRESS : EV_NONE;
    state_nxt = state;
    target_nxt = target;
    pinch_nxt = pinch_seen;
    case (state)
      IDLE_CLOSED: begin
        if (ev == EV_BOTH) state_nxt = FAULT;
        else if (ev == EV_PRESS && !limit_open) begin
          state_nxt = BRAKE;
          target_nxt = OPENING;
        end
      end
      IDLE_OPEN: begin
        if (ev == EV_BOTH) state_nxt = FAULT;
        else if (ev == EV_PRESS && !limit_closed) begin
          state_nxt = BRAKE;
          target_nxt = CLOSING;
          pinch_nxt = 1'b0;
        end
      end
      BRAKE: begin
        if (ev == EV_BOTH) state_nxt = FAULT;
        else if (dead_zero) state_nxt = target;
      end
      OPENING: begin
        if (ev == EV_BOTH || ev == EV_TIMEOUT) state_nxt = FAULT;
        else if (ev == EV_LIMIT || ev == EV_PRESS) begin
          state_nxt = BRAKE;
          target_nxt = IDLE_OPEN;
        end
      end
      CLOSING: begin
        if (ev == EV_BOTH || ev == EV_TIMEOUT) state_nxt = FAULT;
        else if (ev == EV_LIMIT) begin
          state_nxt = BRAKE;
          target_nxt = IDLE_CLOSED;
        end else if (ev == EV_OBST) begin
          state_nxt = BRAKE;
          target_nxt = OPENING;
          pinch_nxt = 1'b1;
        end else if (ev == EV_PRESS) begin
          state_nxt = BRAKE;
          target_nxt = IDLE_OPEN;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE_CLOSED;
      target <= IDLE_CLOSED;
      pinch_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      target <= target_nxt;
      pinch_seen <= pinch_nxt;
    end
  end
  assign motor_cw = state == OPENING;
  assign motor_ccw = state == CLOSING;
  assign busy = !(state == IDLE_CLOSED || state == IDLE_OPEN || state == FAULT);
  assign fault = state == FAULT;
endmodule

// File: tb/tb_window_motor_sequencer.sv
// tb_window_motor_sequencer: directed checks of the window motor sequencer (main instance plus a short-watchdog instance).
module tb_window_motor_sequencer;
  logic clk = 1'b0, nr = 1'b0, bp = 1'b0, lo = 1'b0, lc = 1'b0, ob = 1'b0;
  logic cw, ccw, busy, flt, pinch, w_cw, w_ccw, w_busy, w_flt, w_pinch;
  logic [4:0] o, wo;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  window_motor_sequencer u_dut (
    .clk(clk), .n_reset(nr), .button_press(bp), .limit_open(lo), .limit_closed(lc),
    .obstruction(ob), .motor_cw(cw), .motor_ccw(ccw), .busy(busy), .fault(flt), .pinch_seen(pinch)
  );
  window_motor_sequencer #(.RUN_CYCLES(20)) u_wd (
    .clk(clk), .n_reset(nr), .button_press(bp), .limit_open(lo), .limit_closed(lc),
    .obstruction(ob), .motor_cw(w_cw), .motor_ccw(w_ccw), .busy(w_busy), .fault(w_flt), .pinch_seen(w_pinch)
  );
  assign o = {cw, ccw, busy, flt, pinch};
  assign wo = {w_cw, w_ccw, w_busy, w_flt, w_pinch};
  task tick;
    @(posedge clk);
    #1;
    vecs++;
    if ((cw && ccw) || (w_cw && w_ccw)) begin
      errs++;
      $display("FAIL both_dirs: got cw=%b ccw=%b wd_cw=%b wd_ccw=%b want never both high", cw, ccw, w_cw, w_ccw);
    end
  endtask
  task press;
    bp = 1'b1;
    tick;
    bp = 1'b0;
  endtask
  task do_reset;
    nr = 1'b0; bp = 1'b0; lo = 1'b0; lc = 1'b0; ob = 1'b0;
    tick;
    tick;
    nr = 1'b1;
  endtask
  task go_open;
    do_reset;
    lc = 1'b1;
    press;
    lc = 1'b0;
    repeat (16) tick;
    lo = 1'b1;
    tick;
    repeat (16) tick;
  endtask
  task test_reset;
    do_reset;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL reset_out: got %b want %b", o, 5'b00000); end
    vecs++; if (wo !== 5'b00000) begin errs++; $display("FAIL reset_wd_out: got %b want %b", wo, 5'b00000); end
    lo = 1'b1;
    press;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL press_at_open_limit: got %b want %b", o, 5'b00000); end
    tick;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL press_at_open_limit_2: got %b want %b", o, 5'b00000); end
    lo = 1'b0;
  endtask
  task test_open;
    do_reset;
    lc = 1'b1;
    press;
    lc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL open_dead[%0d]: got %b want %b", i, o, 5'b00100); end
      tick;
    end
    vecs++; if (o !== 5'b10100) begin errs++; $display("FAIL open_start: got %b want %b", o, 5'b10100); end
    repeat (49) tick;
    vecs++; if (o !== 5'b10100) begin errs++; $display("FAIL open_cycle50: got %b want %b", o, 5'b10100); end
    lo = 1'b1;
    tick;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL open_stop_brake[%0d]: got %b want %b", i, o, 5'b00100); end
      tick;
    end
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL open_idle: got %b want %b", o, 5'b00000); end
  endtask
  task test_pinch;
    go_open;
    lo = 1'b0;
    press;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL close_brake: got %b want %b", o, 5'b00100); end
    repeat (16) tick;
    vecs++; if (o !== 5'b01100) begin errs++; $display("FAIL close_start: got %b want %b", o, 5'b01100); end
    repeat (29) tick;
    ob = 1'b1;
    tick;
    ob = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vecs++; if (o !== 5'b00101) begin errs++; $display("FAIL pinch_brake[%0d]: got %b want %b", i, o, 5'b00101); end
      tick;
    end
    vecs++; if (o !== 5'b10101) begin errs++; $display("FAIL pinch_reopen: got %b want %b", o, 5'b10101); end
    press;
    repeat (16) tick;
    vecs++; if (o !== 5'b00001) begin errs++; $display("FAIL pinch_sticky_idle: got %b want %b", o, 5'b00001); end
    press;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL pinch_clear: got %b want %b", o, 5'b00100); end
    repeat (16) tick;
    vecs++; if (o !== 5'b01100) begin errs++; $display("FAIL pinch_reclose: got %b want %b", o, 5'b01100); end
  endtask
  task test_user_stop;
    do_reset;
    lc = 1'b1;
    press;
    lc = 1'b0;
    repeat (16) tick;
    vecs++; if (o !== 5'b10100) begin errs++; $display("FAIL stop_opening: got %b want %b", o, 5'b10100); end
    repeat (10) tick;
    press;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL stop_brake: got %b want %b", o, 5'b00100); end
    repeat (5) tick;
    press;
    repeat (9) tick;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL stop_brake_end: got %b want %b", o, 5'b00100); end
    tick;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL stop_idle_open: got %b want %b", o, 5'b00000); end
    press;
    repeat (16) tick;
    vecs++; if (o !== 5'b01100) begin errs++; $display("FAIL stop_then_close: got %b want %b", o, 5'b01100); end
  endtask
  task test_timeout;
    do_reset;
    lc = 1'b1;
    press;
    lc = 1'b0;
    repeat (16) tick;
    for (int i = 0; i < 20; i++) begin
      vecs++; if (wo !== 5'b10100) begin errs++; $display("FAIL wd_run[%0d]: got %b want %b", i, wo, 5'b10100); end
      tick;
    end
    vecs++; if (wo !== 5'b00010) begin errs++; $display("FAIL wd_fault: got %b want %b", wo, 5'b00010); end
    lo = 1'b1; lc = 1'b1; ob = 1'b1;
    press;
    lo = 1'b0;
    press;
    vecs++; if (wo !== 5'b00010) begin errs++; $display("FAIL wd_fault_hold: got %b want %b", wo, 5'b00010); end
    lc = 1'b0; ob = 1'b0;
    nr = 1'b0;
    tick;
    nr = 1'b1;
    vecs++; if (wo !== 5'b00000) begin errs++; $display("FAIL wd_reset: got %b want %b", wo, 5'b00000); end
    lc = 1'b1;
    press;
    lc = 1'b0;
    vecs++; if (wo !== 5'b00100) begin errs++; $display("FAIL wd_after_reset_press: got %b want %b", wo, 5'b00100); end
  endtask
  task test_both_limits;
    go_open;
    lo = 1'b0;
    press;
    repeat (16) tick;
    vecs++; if (o !== 5'b01100) begin errs++; $display("FAIL both_closing: got %b want %b", o, 5'b01100); end
    repeat (5) tick;
    lo = 1'b1; lc = 1'b1;
    tick;
    vecs++; if (o !== 5'b00010) begin errs++; $display("FAIL both_fault: got %b want %b", o, 5'b00010); end
    lo = 1'b0; lc = 1'b0;
    tick;
    vecs++; if (o !== 5'b00010) begin errs++; $display("FAIL both_fault_hold: got %b want %b", o, 5'b00010); end
  endtask
  task test_reset_mid;
    go_open;
    lo = 1'b0;
    press;
    repeat (16) tick;
    vecs++; if (o !== 5'b01100) begin errs++; $display("FAIL mid_closing: got %b want %b", o, 5'b01100); end
    nr = 1'b0;
    tick;
    nr = 1'b1;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL mid_reset: got %b want %b", o, 5'b00000); end
    press;
    repeat (16) tick;
    vecs++; if (o !== 5'b10100) begin errs++; $display("FAIL mid_reopen: got %b want %b", o, 5'b10100); end
  endtask
  task test_press_limit;
    go_open;
    lo = 1'b0;
    press;
    repeat (16) tick;
    lc = 1'b1;
    press;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL pl_brake: got %b want %b", o, 5'b00100); end
    repeat (16) tick;
    vecs++; if (o !== 5'b00000) begin errs++; $display("FAIL pl_idle: got %b want %b", o, 5'b00000); end
    press;
    vecs++; if (o !== 5'b00100) begin errs++; $display("FAIL pl_idle_closed: got %b want %b", o, 5'b00100); end
    lc = 1'b0;
  endtask
  initial begin
    test_reset;
    test_open;
    test_pinch;
    test_user_stop;
    test_timeout;
    test_both_limits;
    test_reset_mid;
    test_press_limit;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
